pc_cmd_frame_rx: RTL and testbench
==================================

# pc_cmd_frame_rx

Host-link command framer placed directly upstream of the configuration parser. It receives the raw host byte stream and detects frames of the form sync, length, payload, checksum. Each frame's payload is buffered and integrity-checked. Only verified payload bytes go to the parser's `pc_cmd_valid`/`pc_cmd_data` port, one byte per `pc_ack`, so corrupted or truncated host traffic never reaches configuration.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `MAX_LEN`, 16: maximum payload bytes per frame. Range 1..255. Sets the buffer depth.
- `TIMEOUT_CYCLES`, 1000: maximum idle clocks between accepted bytes inside a frame. Must be ≥2.

Ports:
- `clk`, in, 1: single system clock. All logic is in this domain.
- `rst`, in, 1: asynchronous, active-high reset.
- `rx_valid`, in, 1: host byte valid.
- `rx_data`, in, 8: host byte.
- `rx_ready`, out, 1: framer can accept a byte. A byte transfers when `rx_valid & rx_ready` at a rising edge.
- `pc_cmd_valid`, out, 1: verified payload byte is presented to the parser.
- `pc_cmd_data`, out, 8: payload byte.
- `pc_ack`, in, 1: parser consumed the byte presented.
- `frame_ok`, out, 1: one-cycle pulse when a frame is fully delivered.
- `frame_err`, out, 1: one-cycle pulse when a frame is rejected.
- `err_code`, out, 2: last error cause. 1 = bad length, 2 = checksum mismatch, 3 = timeout. Holds until the next error.
- `ok_count`, out, 16: delivered frames. Saturates at 16'hFFFF.
- `err_count`, out, 16: rejected frames. Saturates at 16'hFFFF.

## Operation
- Frame format: `SYNC_BYTE`, `LEN`, `LEN` payload bytes, `CHK`. `CHK` = XOR of `LEN` and all payload bytes.
- FSM states:
  - **HUNT**: `rx_ready`=1. Non-sync bytes are discarded silently (no error, no count). On `SYNC_BYTE`, go to LEN.
  - **LEN**: `rx_ready`=1. Accept `LEN`.
    - `LEN`=0 or `LEN`>`MAX_LEN`: error code 1, go to HUNT.
    - Otherwise: store `LEN`, set the running checksum to `LEN`, clear the write index, go to PAYLOAD.
  - **PAYLOAD**: `rx_ready`=1. Write each accepted byte to `buf[index]`, XOR it into the checksum, and increment the index. When index reaches `LEN`, go to CHK.
  - **CHK**: `rx_ready`=1. Accept `CHK`.
    - Equal to the running checksum: go to RELEASE with the read index at 0.
    - Not equal: error code 2, go to HUNT.
  - **RELEASE**: `rx_ready`=0, so host bytes stall. `pc_cmd_valid`=1 and `pc_cmd_data`=`buf[read index]`.
    - On `pc_ack`=1, advance the read index.
    - After the byte at index `LEN`-1 is acked, deassert valid, pulse `frame_ok`, increment `ok_count`, go to HUNT.
- A `SYNC_BYTE` value inside LEN, PAYLOAD or CHK is treated as data, not as a resync.
- Timeout: an idle counter runs in LEN, PAYLOAD and CHK.
  - It clears on every accepted byte and on entry to LEN.
  - It increments on each clock with no transfer.
  - The clock on which it would reach `TIMEOUT_CYCLES` raises error code 3 and returns to HUNT.
  - No timeout applies in HUNT or RELEASE. Parser backpressure is unbounded.
- Any error: pulse `frame_err`, update `err_code`, increment `err_count` (saturating), and discard the partial frame. Nothing is emitted on `pc_cmd_*`.
- `pc_ack` while `pc_cmd_valid`=0 is ignored.
- Buffer: `MAX_LEN`×8 registers. Length and index counters are `$clog2(MAX_LEN+1)` bits wide.

## Timing
- Reset values: FSM in HUNT, `rx_ready`=1, `pc_cmd_valid`=0, `pc_cmd_data`=0, `frame_ok`=0, `frame_err`=0, `err_code`=0, both counters 0.
- Reset mid-frame or mid-release drops the frame immediately. No pulse and no count change.
- All outputs are registered.
- `pc_cmd_valid` rises on the edge that accepts a correct `CHK`. The first byte is visible in the following cycle.
- Each `pc_ack` advances the byte at the same edge. Back-to-back acks give 1 byte/clock.
- `pc_cmd_data` is stable while valid and unacked.
- `frame_ok` is high for exactly the one cycle after the final ack edge. `rx_ready` returns to 1 in that same cycle.
- `frame_err` is high for the one cycle after the offending byte's edge or the timeout edge. `err_code` and `err_count` update on that same edge.
- Minimum frame-to-delivery latency: `LEN`+3 transfer cycles plus `LEN` ack cycles.

## Test plan
- Good frame: A5 02 11 22 31, `pc_ack` held 1. Expect `pc_cmd_data` 11 then 22 on consecutive cycles, `frame_ok` pulse, `ok_count`=1.
- Bad checksum: A5 02 11 22 30. Expect `frame_err`, `err_code`=2, `err_count`=1, `pc_cmd_valid` never asserted. A following good frame is still delivered.
- Length limits:
  - A5 00 gives error code 1.
  - A5 11 (`MAX_LEN`=16) gives error code 1.
  - A5 10, 16 bytes, correct `CHK` delivers all 16 bytes.
- Hunt and resync: 00 FF A5 01 7E 7F. Expect a single byte 7E delivered and no error.
- Timeout: A5 03 11, then `rx_valid`=0. Expect `frame_err` with code 3 exactly 1000 idle clocks later, and the state returns to HUNT.
- Backpressure and reset:
  - Good frame with each `pc_ack` delayed 5 cycles: expect data held, `rx_ready`=0 throughout RELEASE.
  - Assert `rst` after the first ack: expect all outputs at reset values and no `frame_ok`.

Source files
------------

// File: rtl/pc_cmd_frame_rx.sv
// Host-link command framer: hunts for SYNC, buffers LEN payload bytes, verifies the XOR
// checksum and only then releases the payload to the configuration parser, one byte per ack.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// HUNT     | discard host bytes until SYNC_BYTE
// LEN      | expect length byte (1..MAX_LEN)
// PAYLOAD  | store payload into buffer, fold into running checksum
// CHK      | compare checksum byte, release or reject
// RELEASE  | present verified bytes to parser, host stalled
module pc_cmd_frame_rx #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        pc_cmd_valid_o,
    output logic [7:0]  pc_cmd_data_o,
    input  logic        pc_ack_i,
    output logic        frame_ok_o,
    output logic        frame_err_o,
    output logic [1:0]  err_code_o,
    output logic [15:0] ok_count_o,
    output logic [15:0] err_count_o
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] IDLE_TOP  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_RELEASE
    } state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   idx_q, idx_d;
    logic [7:0]      chk_q, chk_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic [7:0]      buf_q [MAX_LEN];
    logic            rx_ready_q, rx_ready_d;
    logic            valid_q, valid_d;
    logic [7:0]      data_q, data_d;
    logic            ok_q, ok_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic [15:0]     okc_q, okc_d;
    logic [15:0]     errc_q, errc_d;
    logic            buf_we;
    logic            err_hit;
    logic [1:0]      err_cause;
    logic            xfer;

    assign xfer = rx_valid_i & rx_ready_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        idle_d    = idle_q;
        data_d    = data_q;
        code_d    = code_q;
        okc_d     = okc_q;
        errc_d    = errc_q;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        buf_we    = 1'b0;
        err_hit   = 1'b0;
        err_cause = 2'd0;

        case (state_q)
            ST_HUNT: begin
                idle_d = IDLE_TOP;
                if (xfer && rx_data_i == SYNC_BYTE) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (xfer) begin
                    if (rx_data_i == 8'd0 || rx_data_i > MAX_LEN_B) begin
                        err_hit   = 1'b1;
                        err_cause = 2'd1;
                    end else begin
                        len_d   = rx_data_i[LW-1:0];
                        chk_d   = rx_data_i;
                        idx_d   = '0;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ rx_data_i;
                    idx_d  = idx_q + LW'(1);
                    if (idx_d == len_q) state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (xfer) begin
                    if (rx_data_i == chk_q) begin
                        idx_d   = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        err_hit   = 1'b1;
                        err_cause = 2'd2;
                    end
                end
            end
            ST_RELEASE: begin
                if (pc_ack_i) begin
                    idx_d = idx_q + LW'(1);
                    if (idx_d == len_q) begin
                        state_d = ST_HUNT;
                        ok_d    = 1'b1;
                        if (okc_q != 16'hFFFF) okc_d = okc_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase

        // Idle down-counter: terminal count on an idle clock is the timeout.
        if (state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CHK) begin
            if (xfer) begin
                idle_d = IDLE_TOP;
            end else if (idle_q == '0) begin
                err_hit   = 1'b1;
                err_cause = 2'd3;
            end else begin
                idle_d = idle_q - TW'(1);
            end
        end

        if (err_hit) begin
            state_d = ST_HUNT;
            err_d   = 1'b1;
            code_d  = err_cause;
            if (errc_q != 16'hFFFF) errc_d = errc_q + 16'd1;
        end

        rx_ready_d = (state_d != ST_RELEASE);
        valid_d    = (state_d == ST_RELEASE);
        if (state_d == ST_RELEASE) data_d = buf_q[idx_d[AW-1:0]];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_HUNT;
            len_q      <= '0;
            idx_q      <= '0;
            chk_q      <= '0;
            idle_q     <= IDLE_TOP;
            rx_ready_q <= 1'b1;
            valid_q    <= 1'b0;
            data_q     <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= '0;
            okc_q      <= '0;
            errc_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            chk_q      <= chk_d;
            idle_q     <= idle_d;
            rx_ready_q <= rx_ready_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            code_q     <= code_d;
            okc_q      <= okc_d;
            errc_q     <= errc_d;
        end
    end

    // Payload storage needs no reset: it is only read after being written.
    always_ff @(posedge clk_i) begin
        if (buf_we) buf_q[idx_q[AW-1:0]] <= rx_data_i;
    end

    assign rx_ready_o     = rx_ready_q;
    assign pc_cmd_valid_o = valid_q;
    assign pc_cmd_data_o  = data_q;
    assign frame_ok_o     = ok_q;
    assign frame_err_o    = err_q;
    assign err_code_o     = code_q;
    assign ok_count_o     = okc_q;
    assign err_count_o    = errc_q;

endmodule

// File: tb/tb_pc_cmd_frame_rx.sv
// Self-checking bench for pc_cmd_frame_rx: table vectors, hand-written corner sequences
// and randomized frames checked against a frame-level expectation model.
module tb_pc_cmd_frame_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        pc_cmd_valid;
    logic [7:0]  pc_cmd_data;
    logic        pc_ack;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] ok_count;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    pc_cmd_frame_rx #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYCLES(1000)) dut (
        .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .rx_ready_o(rx_ready), .pc_cmd_valid_o(pc_cmd_valid), .pc_cmd_data_o(pc_cmd_data),
        .pc_ack_i(pc_ack), .frame_ok_o(frame_ok), .frame_err_o(frame_err),
        .err_code_o(err_code), .ok_count_o(ok_count), .err_count_o(err_count)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [7:0] got_b[$];
    int         got_c[$];
    int         got_e[$];
    int         ok_seen = 0;
    int         ok_cyc = 0;
    int         ack_mode = 0;
    int         wait_cnt = 0;
    logic       prev_v = 1'b0;
    logic       prev_a = 1'b0;
    logic [7:0] prev_d = 8'h00;
    int         exp_okc = 0;
    int         exp_errc = 0;

    typedef struct {
        int           n;
        logic [191:0] b;
        int           ok;
        int           code;
        int           en;
        logic [127:0] e;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: collects delivered bytes, pulses and protocol invariants.
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            check("ready_vs_valid", int'(rx_ready), int'(!pc_cmd_valid));
            if (prev_v && !prev_a && pc_cmd_valid) check("data_hold", int'(pc_cmd_data), int'(prev_d));
            if (pc_cmd_valid && pc_ack) begin
                got_b.push_back(pc_cmd_data);
                got_c.push_back(cyc);
            end
            if (frame_ok) begin
                ok_seen++;
                ok_cyc = cyc;
            end
            if (frame_err) got_e.push_back(int'(err_code));
            prev_v = pc_cmd_valid;
            prev_a = pc_ack;
            prev_d = pc_cmd_data;
        end
    end

    // Parser ack driver: 0 = always ack, 1 = ack after 5 stalled cycles, 2 = random.
    initial begin
        pc_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0: pc_ack = 1'b1;
                1: begin
                    if (pc_cmd_valid && wait_cnt == 5) begin
                        pc_ack   = 1'b1;
                        wait_cnt = 0;
                    end else begin
                        pc_ack = 1'b0;
                        if (pc_cmd_valid) wait_cnt++;
                    end
                end
                default: pc_ack = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   guard = 0;
        logic r;
        rx_valid = 1'b1;
        rx_data  = b;
        do begin
            @(negedge clk);
            r = rx_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!r && guard < 500);
        if (!r) begin
            tests++;
            fails++;
            $display("FAIL send_stall: byte %0h not accepted after %0d cycles", b, guard);
        end
    endtask

    task automatic wait_ok(input int target, input int budget);
        for (int g = 0; g < budget && ok_seen < target; g++) cycles(1);
    endtask

    task automatic clear_mon();
        got_b.delete();
        got_c.delete();
        got_e.delete();
        ok_seen = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"},  int'(rx_ready), 1);
        check({tag, "_valid"},     int'(pc_cmd_valid), 0);
        check({tag, "_data"},      int'(pc_cmd_data), 0);
        check({tag, "_frame_ok"},  int'(frame_ok), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
        check({tag, "_err_code"},  int'(err_code), 0);
        check({tag, "_ok_count"},  int'(ok_count), 0);
        check({tag, "_err_count"}, int'(err_count), 0);
    endtask

    task automatic add_vec(input int n, input logic [191:0] b, input int ok, input int code,
                           input int en, input logic [127:0] e);
        vec_t v;
        v.n = n; v.b = b; v.ok = ok; v.code = code; v.en = en; v.e = e;
        vecs.push_back(v);
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        string nm;
        nm = $sformatf("vec%0d", idx);
        clear_mon();
        for (int i = 0; i < v.n; i++) send_byte(v.b[8*(v.n-1-i) +: 8]);
        rx_valid = 1'b0;
        for (int g = 0; g < 200 && ok_seen == 0 && got_e.size() == 0; g++) cycles(1);
        cycles(3);
        exp_okc  += v.ok;
        exp_errc += (v.code != 0) ? 1 : 0;
        check({nm, "_nbytes"}, got_b.size(), v.en);
        if (got_b.size() == v.en)
            for (int i = 0; i < v.en; i++)
                check({nm, "_byte"}, int'(got_b[i]), int'(v.e[8*(v.en-1-i) +: 8]));
        check({nm, "_ok_pulses"}, ok_seen, v.ok);
        check({nm, "_err_pulses"}, got_e.size(), (v.code != 0) ? 1 : 0);
        if (v.code != 0 && got_e.size() > 0) check({nm, "_err_code"}, got_e[0], v.code);
        check({nm, "_ok_count"}, int'(ok_count), exp_okc);
        check({nm, "_err_count"}, int'(err_count), exp_errc);
        if (v.ok == 1 && got_c.size() == v.en) begin
            for (int i = 1; i < v.en; i++) check({nm, "_burst"}, got_c[i] - got_c[i-1], 1);
            check({nm, "_ok_timing"}, ok_cyc - got_c[v.en-1], 1);
        end
    endtask

    // Random frame generator; the expectation follows from the kind of frame built.
    task automatic rand_frame(input int kind, inout logic [7:0] exp_b[$], inout int exp_e[$],
                              inout int exp_ok);
        logic [7:0] q[$];
        logic [7:0] c, p, len;
        int         ng, cut;
        if (kind == 1) begin
            ng = $urandom_range(1, 3);
            for (int i = 0; i < ng; i++) begin
                p = 8'($urandom_range(0, 255));
                if (p == 8'hA5) p = 8'h5A;
                q.push_back(p);
            end
        end
        q.push_back(8'hA5);
        if (kind == 3) begin
            len = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(17, 255));
            q.push_back(len);
            exp_e.push_back(1);
        end else begin
            len = 8'($urandom_range(1, 16));
            q.push_back(len);
            c = len;
            for (int i = 0; i < int'(len); i++) begin
                p = 8'($urandom_range(0, 255));
                q.push_back(p);
                c = c ^ p;
                if (kind <= 1) exp_b.push_back(p);
            end
            if (kind == 2) begin
                q.push_back(c ^ 8'($urandom_range(1, 255)));
                exp_e.push_back(2);
            end else if (kind == 4) begin
                cut = $urandom_range(1, q.size() - 1);
                while (q.size() > cut) void'(q.pop_back());
                exp_e.push_back(3);
            end else begin
                q.push_back(c);
                exp_ok++;
            end
        end
        foreach (q[i]) begin
            rx_valid = 1'b0;
            cycles($urandom_range(0, 3));
            send_byte(q[i]);
        end
        rx_valid = 1'b0;
        if (kind == 4) cycles(1005);
    endtask

    initial begin
        logic [7:0] exp_b[$];
        int         exp_e[$];
        int         exp_ok;
        int         k;

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        cycles(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        cycles(2);
        check("post_reset_ready", int'(rx_ready), 1);

        add_vec(5,  192'hA5_02_11_22_31, 1, 0, 2, 128'h11_22);
        add_vec(5,  192'hA5_02_11_22_30, 0, 2, 0, 128'h0);
        add_vec(5,  192'hA5_02_11_22_31, 1, 0, 2, 128'h11_22);
        add_vec(2,  192'hA5_00,          0, 1, 0, 128'h0);
        add_vec(2,  192'hA5_11,          0, 1, 0, 128'h0);
        add_vec(20, 192'hA5_10_0102030405060708090A0B0C0D0E0F10_00, 1, 0, 16,
                128'h0102030405060708090A0B0C0D0E0F10);
        add_vec(6,  192'h00_FF_A5_01_7E_7F, 1, 0, 1, 128'h7E);
        add_vec(4,  192'hA5_01_A5_A4,    1, 0, 1, 128'hA5);
        ack_mode = 0;
        foreach (vecs[i]) apply_vec(i, vecs[i]);

        // Timeout: exactly 1000 idle clocks after the last accepted byte.
        clear_mon();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        rx_valid = 1'b0;
        k = 0;
        while (!frame_err && k < 1100) begin
            cycles(1);
            k++;
        end
        exp_errc++;
        check("timeout_cycles", k, 1000);
        check("timeout_code", int'(err_code), 3);
        check("timeout_err_count", int'(err_count), exp_errc);
        check("timeout_ready", int'(rx_ready), 1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        rx_valid = 1'b0;
        wait_ok(1, 100);
        exp_okc++;
        check("after_timeout_ok", ok_seen, 1);
        check("after_timeout_nbytes", got_b.size(), 1);
        if (got_b.size() == 1) check("after_timeout_byte", int'(got_b[0]), 8'h7E);

        // Backpressure: each ack 5 cycles late; the next frame queues behind the release.
        clear_mon();
        ack_mode = 1; wait_cnt = 0;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'hC1); send_byte(8'hC2);
        send_byte(8'hC3); send_byte(8'hC3);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        rx_valid = 1'b0;
        wait_ok(2, 300);
        exp_okc += 2;
        check("bp_ok", ok_seen, 2);
        check("bp_nbytes", got_b.size(), 4);
        if (got_b.size() == 4) begin
            check("bp_b0", int'(got_b[0]), 8'hC1);
            check("bp_b1", int'(got_b[1]), 8'hC2);
            check("bp_b2", int'(got_b[2]), 8'hC3);
            check("bp_b3", int'(got_b[3]), 8'h7E);
            check("bp_gap1", got_c[1] - got_c[0], 6);
            check("bp_gap2", got_c[2] - got_c[1], 6);
        end
        check("bp_ok_count", int'(ok_count), exp_okc);

        // Reset after the first ack of a release.
        clear_mon();
        wait_cnt = 0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h55); send_byte(8'h66); send_byte(8'h31);
        rx_valid = 1'b0;
        for (int g = 0; g < 100 && got_b.size() == 0; g++) cycles(1);
        check("rst_first_byte", got_b.size(), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        cycles(2);
        rst = 1'b0;
        ack_mode = 0;
        cycles(10);
        check("midrst_no_ok", ok_seen, 0);
        check("midrst_ok_count", int'(ok_count), 0);
        exp_okc = 0; exp_errc = 0;

        // Randomized frames with random acks and host gaps.
        clear_mon();
        ack_mode = 2;
        exp_ok = 0;
        for (int f = 0; f < 150; f++) begin
            int kind;
            kind = (f == 40 || f == 110) ? 4 : $urandom_range(0, 3);
            rand_frame(kind, exp_b, exp_e, exp_ok);
        end
        for (int g = 0; g < 3000 && (got_b.size() < exp_b.size() || ok_seen < exp_ok); g++)
            cycles(1);
        cycles(5);
        check("rand_nbytes", got_b.size(), exp_b.size());
        if (got_b.size() == exp_b.size())
            foreach (exp_b[i]) check("rand_byte", int'(got_b[i]), int'(exp_b[i]));
        check("rand_nerr", got_e.size(), exp_e.size());
        if (got_e.size() == exp_e.size())
            foreach (exp_e[i]) check("rand_err_code", got_e[i], exp_e[i]);
        check("rand_ok_pulses", ok_seen, exp_ok);
        check("rand_ok_count", int'(ok_count), exp_ok);
        check("rand_err_count", int'(err_count), exp_e.size());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
